// File: rtl/ppu_regs_pkg.sv
// PPU B-bus register offsets shared by the PPU register decoders, plus the
// CGRAM CPU-port sequencer state type.
package ppu_regs_pkg;

    localparam logic [7:0] REG_CGADD  = 8'h21;
    localparam logic [7:0] REG_CGDATA = 8'h22;
    localparam logic [7:0] REG_CGREAD = 8'h3B;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DATA = 2'd2
    } cgram_state_t;

endpackage

// File: rtl/ppu_cgram_port.sv
// CPU-side access controller for the 256x15 palette RAM (CGRAM), port A.
// Handles CGADD / CGDATA / CGDATAREAD: address counter, shared low/high byte
// flip-flop, write low-byte latch and the 1-cycle-latency BRAM read.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | accepting strobes; writes finish here in one clock
//  RD_WAIT | read issued to the BRAM (cg_cea high, cg_wrea low)
//  RD_DATA | cg_douta valid; result loaded into pa_dout, valid pulsed
module ppu_cgram_port #(
    parameter int         ADDR_W     = 8,
    parameter int         DATA_W     = 15,
    parameter logic [7:0] REG_CGADD  = ppu_regs_pkg::REG_CGADD,
    parameter logic [7:0] REG_CGDATA = ppu_regs_pkg::REG_CGDATA,
    parameter logic [7:0] REG_CGREAD = ppu_regs_pkg::REG_CGREAD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        pa_addr,
    input  logic              pa_wr,
    input  logic              pa_rd,
    input  logic [7:0]        pa_din,
    input  logic              ob_bit7,
    output logic [7:0]        pa_dout,
    output logic              pa_dout_valid,
    output logic              cg_cea,
    output logic              cg_wrea,
    output logic [ADDR_W-1:0] cg_ada,
    output logic [DATA_W-1:0] cg_dina,
    input  logic [DATA_W-1:0] cg_douta
);
    import ppu_regs_pkg::*;

    cgram_state_t      r_state;
    cgram_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_cg_addr;
    logic              r_ff;
    logic [7:0]        r_lo_latch;
    logic [7:0]        r_pa_dout;
    logic              r_pa_dout_valid;
    logic              r_cg_cea;
    logic              r_cg_wrea;
    logic [ADDR_W-1:0] r_cg_ada;
    logic [DATA_W-1:0] r_cg_dina;

    logic w_idle;
    logic w_wr_add;
    logic w_wr_data;
    logic w_rd_start;

    // Strobes are only honoured in IDLE; a write strobe always shadows a read.
    assign w_idle     = (r_state == IDLE);
    assign w_wr_add   = w_idle && pa_wr && (pa_addr == REG_CGADD);
    assign w_wr_data  = w_idle && pa_wr && (pa_addr == REG_CGDATA);
    assign w_rd_start = w_idle && !pa_wr && pa_rd && (pa_addr == REG_CGREAD);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a read walks IDLE -> RD_WAIT -> RD_DATA -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_rd_start) w_state_nxt = RD_WAIT;
            RD_WAIT: w_state_nxt = RD_DATA;
            RD_DATA: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: address counter, byte flip-flop, low-byte latch and RAM port drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cg_addr       <= '0;
            r_ff            <= 1'b0;
            r_lo_latch      <= 8'h00;
            r_pa_dout       <= 8'h00;
            r_pa_dout_valid <= 1'b0;
            r_cg_cea        <= 1'b0;
            r_cg_wrea       <= 1'b0;
            r_cg_ada        <= '0;
            r_cg_dina       <= '0;
        end else begin
            r_cg_cea        <= 1'b0;
            r_cg_wrea       <= 1'b0;
            r_pa_dout_valid <= 1'b0;

            if (w_wr_add) begin
                r_cg_addr <= pa_din[ADDR_W-1:0];
                r_ff      <= 1'b0;
            end else if (w_wr_data) begin
                if (!r_ff) begin
                    r_lo_latch <= pa_din;
                    r_ff       <= 1'b1;
                end else begin
                    // pa_din[7] has no storage in a 15-bit BGR555 word.
                    r_cg_cea  <= 1'b1;
                    r_cg_wrea <= 1'b1;
                    r_cg_ada  <= r_cg_addr;
                    r_cg_dina <= {pa_din[6:0], r_lo_latch};
                    r_cg_addr <= r_cg_addr + 1'b1;
                    r_ff      <= 1'b0;
                end
            end else if (w_rd_start) begin
                r_cg_cea <= 1'b1;
                r_cg_ada <= r_cg_addr;
            end

            // BRAM output registered on the RD_WAIT edge is stable through RD_DATA.
            if (r_state == RD_DATA) begin
                r_pa_dout_valid <= 1'b1;
                if (!r_ff) begin
                    r_pa_dout <= cg_douta[7:0];
                    r_ff      <= 1'b1;
                end else begin
                    r_pa_dout <= {ob_bit7, cg_douta[14:8]};
                    r_ff      <= 1'b0;
                    r_cg_addr <= r_cg_addr + 1'b1;
                end
            end
        end
    end

    assign pa_dout       = r_pa_dout;
    assign pa_dout_valid = r_pa_dout_valid;
    assign cg_cea        = r_cg_cea;
    assign cg_wrea       = r_cg_wrea;
    assign cg_ada        = r_cg_ada;
    assign cg_dina       = r_cg_dina;

endmodule

// File: tb/tb_ppu_cgram_port.sv
// Directed bench for ppu_cgram_port with a behavioural 256x15 BRAM on port A.
module tb_ppu_cgram_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pa_addr;
    logic        pa_wr;
    logic        pa_rd;
    logic [7:0]  pa_din;
    logic        ob_bit7;
    logic [7:0]  pa_dout;
    logic        pa_dout_valid;
    logic        cg_cea;
    logic        cg_wrea;
    logic [7:0]  cg_ada;
    logic [14:0] cg_dina;
    logic [14:0] cg_douta;

    logic [14:0] mem [256];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ppu_cgram_port dut (
        .clk          (clk),
        .reset        (reset),
        .pa_addr      (pa_addr),
        .pa_wr        (pa_wr),
        .pa_rd        (pa_rd),
        .pa_din       (pa_din),
        .ob_bit7      (ob_bit7),
        .pa_dout      (pa_dout),
        .pa_dout_valid(pa_dout_valid),
        .cg_cea       (cg_cea),
        .cg_wrea      (cg_wrea),
        .cg_ada       (cg_ada),
        .cg_dina      (cg_dina),
        .cg_douta     (cg_douta)
    );

    // Single-port BRAM, 1-clock read latency.
    always @(posedge clk) begin
        if (cg_cea) begin
            if (cg_wrea) mem[cg_ada] <= cg_dina;
            else         cg_douta    <= mem[cg_ada];
        end
    end

    typedef struct {
        logic        wr;
        logic        rd;
        logic [7:0]  addr;
        logic [7:0]  din;
        logic        ob;
        logic        exp_wr;
        logic [7:0]  exp_ada;
        logic [14:0] exp_dina;
        logic        exp_rd;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(logic wr, logic rd, logic [7:0] a, logic [7:0] d, logic ob,
                                logic ew, logic [7:0] ea, logic [14:0] ed,
                                logic er, logic [7:0] eo);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = a; v.din = d; v.ob = ob;
        v.exp_wr = ew; v.exp_ada = ea; v.exp_dina = ed;
        v.exp_rd = er; v.exp_dout = eo;
        return v;
    endfunction

    // Plain write with no RAM access expected.
    function automatic vec_t wv(logic [7:0] a, logic [7:0] d);
        return mk(1'b1, 1'b0, a, d, 1'b0, 1'b0, 8'h00, 15'h0, 1'b0, 8'h00);
    endfunction

    // High-byte CGDATA write expected to hit the RAM.
    function automatic vec_t ww(logic [7:0] d, logic [7:0] ea, logic [14:0] ed);
        return mk(1'b1, 1'b0, 8'h22, d, 1'b0, 1'b1, ea, ed, 1'b0, 8'h00);
    endfunction

    // CGDATAREAD with expected returned byte.
    function automatic vec_t rv(logic ob, logic [7:0] eo);
        return mk(1'b0, 1'b1, 8'h3B, 8'h00, ob, 1'b0, 8'h00, 15'h0, 1'b1, eo);
    endfunction

    // One strobe, then watch four clocks of port activity.
    task automatic apply(input logic wr, input logic rd, input logic [7:0] addr,
                         input logic [7:0] din, input logic ob,
                         output int n_wr, output int n_rdc, output logic [7:0] ada,
                         output logic [14:0] dina, output int n_val, output int val_k,
                         output logic [7:0] dout);
        n_wr = 0; n_rdc = 0; n_val = 0; val_k = 0;
        ada = 8'h00; dina = 15'h0; dout = 8'h00;
        @(negedge clk);
        pa_wr = wr; pa_rd = rd; pa_addr = addr; pa_din = din; ob_bit7 = ob;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            pa_wr = 1'b0; pa_rd = 1'b0;
            if (cg_cea && cg_wrea) begin n_wr++; ada = cg_ada; dina = cg_dina; end
            if (cg_cea && !cg_wrea) n_rdc++;
            if (pa_dout_valid) begin n_val++; val_k = k; dout = pa_dout; end
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int n_wr, n_rdc, n_val, val_k;
        logic [7:0] ada, dout;
        logic [14:0] dina;
        apply(v.wr, v.rd, v.addr, v.din, v.ob, n_wr, n_rdc, ada, dina, n_val, val_k, dout);
        chk({tag, " wr_pulses"}, 32'(n_wr), 32'(v.exp_wr));
        chk({tag, " rd_pulses"}, 32'(n_rdc), 32'(v.exp_rd));
        chk({tag, " valid_pulses"}, 32'(n_val), 32'(v.exp_rd));
        if (v.exp_wr) begin
            chk({tag, " cg_ada"}, 32'(ada), 32'(v.exp_ada));
            chk({tag, " cg_dina"}, 32'(dina), 32'(v.exp_dina));
        end
        if (v.exp_rd) begin
            chk({tag, " latency"}, 32'(val_k), 32'd3);
            chk({tag, " pa_dout"}, 32'(dout), 32'(v.exp_dout));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " cg_cea"}, 32'(cg_cea), 32'd0);
        chk({tag, " cg_wrea"}, 32'(cg_wrea), 32'd0);
        chk({tag, " cg_ada"}, 32'(cg_ada), 32'd0);
        chk({tag, " cg_dina"}, 32'(cg_dina), 32'd0);
        chk({tag, " pa_dout"}, 32'(pa_dout), 32'd0);
        chk({tag, " pa_dout_valid"}, 32'(pa_dout_valid), 32'd0);
    endtask

    initial begin
        int n_val, val_k;
        logic [7:0] dout;

        for (int i = 0; i < 256; i++) mem[i] = 15'h0;
        cg_douta = 15'h0;
        reset = 1'b1; pa_addr = 8'h00; pa_wr = 1'b0; pa_rd = 1'b0; pa_din = 8'h00; ob_bit7 = 1'b0;

        // Main table, walked in order; flip-flop and address state carry across rows.
        vecs.push_back(wv(8'h21, 8'h10));
        vecs.push_back(wv(8'h22, 8'h1F));
        vecs.push_back(ww(8'h7C, 8'h10, 15'h7C1F));
        vecs.push_back(wv(8'h22, 8'h21));
        vecs.push_back(ww(8'h03, 8'h11, 15'h0321));
        vecs.push_back(wv(8'h21, 8'h05));
        vecs.push_back(wv(8'h22, 8'h1F));
        vecs.push_back(ww(8'h7C, 8'h05, 15'h7C1F));
        vecs.push_back(wv(8'h21, 8'h05));
        vecs.push_back(rv(1'b0, 8'h1F));
        vecs.push_back(rv(1'b1, 8'hFC));
        vecs.push_back(wv(8'h22, 8'h11));
        vecs.push_back(ww(8'h22, 8'h06, 15'h2211));
        vecs.push_back(wv(8'h21, 8'hFF));
        vecs.push_back(wv(8'h22, 8'hAA));
        vecs.push_back(ww(8'h55, 8'hFF, 15'h55AA));
        vecs.push_back(wv(8'h22, 8'h01));
        vecs.push_back(ww(8'h82, 8'h00, 15'h0201));
        vecs.push_back(wv(8'h22, 8'h12));
        vecs.push_back(wv(8'h21, 8'h40));
        vecs.push_back(wv(8'h22, 8'h34));
        vecs.push_back(ww(8'h01, 8'h40, 15'h0134));
        vecs.push_back(wv(8'h21, 8'h05));
        vecs.push_back(wv(8'h22, 8'h99));
        vecs.push_back(rv(1'b0, 8'h7C));
        vecs.push_back(wv(8'h22, 8'h44));
        vecs.push_back(ww(8'h05, 8'h06, 15'h0544));
        vecs.push_back(wv(8'h22, 8'h10));
        vecs.push_back(wv(8'h23, 8'h77));
        vecs.push_back(mk(1'b0, 1'b1, 8'h3C, 8'h00, 1'b0, 1'b0, 8'h00, 15'h0, 1'b0, 8'h00));
        vecs.push_back(mk(1'b1, 1'b1, 8'h3B, 8'h00, 1'b0, 1'b0, 8'h00, 15'h0, 1'b0, 8'h00));
        vecs.push_back(ww(8'h20, 8'h07, 15'h2010));
        vecs.push_back(wv(8'h21, 8'hFF));
        vecs.push_back(rv(1'b1, 8'hAA));
        vecs.push_back(rv(1'b0, 8'h55));
        vecs.push_back(wv(8'h22, 8'h0A));
        vecs.push_back(ww(8'h0B, 8'h00, 15'h0B0A));

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

        // A CGADD write while a read is in flight must be dropped.
        run_vec("busy_setadd", wv(8'h21, 8'h10));
        n_val = 0; val_k = 0; dout = 8'h00;
        @(negedge clk);
        pa_rd = 1'b1; pa_addr = 8'h3B; ob_bit7 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            pa_rd = 1'b0;
            pa_wr = (k == 1);
            pa_addr = (k == 1) ? 8'h21 : 8'h00;
            pa_din = 8'h80;
            if (pa_dout_valid) begin n_val++; val_k = k; dout = pa_dout; end
        end
        pa_wr = 1'b0;
        chk("busy valid_pulses", 32'(n_val), 32'd1);
        chk("busy latency", 32'(val_k), 32'd3);
        chk("busy pa_dout", 32'(dout), 32'h1F);
        run_vec("busy_hi", rv(1'b1, 8'hFC));
        run_vec("busy_lo", wv(8'h22, 8'h01));
        run_vec("busy_wr", ww(8'h02, 8'h11, 15'h0201));

        // Reset while the read sits in RD_WAIT: abort, clear outputs, address back to 0.
        n_val = 0;
        @(negedge clk);
        pa_rd = 1'b1; pa_addr = 8'h3B;
        @(negedge clk);
        pa_rd = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_rdwait");
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (pa_dout_valid) n_val++;
        end
        chk("rst_rdwait valid_pulses", 32'(n_val), 32'd0);
        run_vec("rst_lo", wv(8'h22, 8'h66));
        run_vec("rst_wr", ww(8'h07, 8'h00, 15'h0766));

        // Reset coincident with a CGADD strobe: reset wins.
        @(negedge clk);
        reset = 1'b1; pa_wr = 1'b1; pa_addr = 8'h21; pa_din = 8'h55;
        @(negedge clk);
        reset = 1'b0; pa_wr = 1'b0;
        run_vec("rst_strobe_lo", wv(8'h22, 8'h03));
        run_vec("rst_strobe_wr", ww(8'h04, 8'h00, 15'h0403));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
